// File: rtl/cnt_pkg.sv
// Shared types and helpers for the modulo counter
// and the display-scan prescalers.
package cnt_pkg;

  // Default prescaler for the 100 MHz board (2 Hz).
  localparam int BOARD_DIV = 50_000_000;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of mod_counter.
// Controls: sclr_n, load_n, d, p, t, up (+cmp); status: q, rco, tick (+match).
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             sclr_n;
  logic             load_n;
  logic [WIDTH-1:0] d;
  logic             p;
  logic             t;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             rco;
  logic             tick;
`ifdef CNT_CMP_EN
  logic [WIDTH-1:0] cmp;
  logic             match;
`endif

  modport master (
    output sclr_n, load_n, d, p, t, up,
`ifdef CNT_CMP_EN
    output cmp,
    input  match,
`endif
    input  q, rco, tick
  );

  modport slave (
    input  sclr_n, load_n, d, p, t, up,
`ifdef CNT_CMP_EN
    input  cmp,
    output match,
`endif
    output q, rco, tick
  );

endinterface

// File: rtl/mod_counter_tick_gen.sv
// Free-running prescaler: tick is high for one clk
// after the count reaches DIV-1. Ports: clk, clear (async low), tick.
module tick_gen
  import cnt_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int CW =
    (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/mod_counter.sv
// Modulo-MOD up/down counter with P/T enables, sync clear/load, rco.
// Ports: clk, clear (async low), bus (slave). Option: CNT_CMP_EN adds cmp/match.
module mod_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16,
  parameter int DIV   = 1
) (
  input  logic clk,
  input  logic clear,
  mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tick;
  dir_e             dir;

  assign dir = dir_e'(bus.up);

  tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .clear(clear),
    .tick (tick)
  );

  // Out-of-range loaded values wrap to 0 on an up-step.
  always_comb begin
    q_d = q_q;
    if (!bus.sclr_n) begin
      q_d = '0;
    end else if (!bus.load_n) begin
      q_d = bus.d;
    end else if (bus.p && bus.t && tick) begin
      if (dir == DIR_UP)
        q_d = (q_q >= MAXV) ? '0 : q_q + 1'b1;
      else
        q_d = (q_q == '0) ? MAXV : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) q_q <= '0;
    else        q_q <= q_d;
  end

  assign bus.q    = q_q;
  assign bus.tick = tick;
  assign bus.rco  = bus.t &
    ((dir == DIR_UP) ? (q_q == MAXV) : (q_q == '0));

`ifdef CNT_CMP_EN
  logic match_q;

  // Compare the next value so match lines up with q.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) match_q <= 1'b0;
    else        match_q <= (q_d == bus.cmp);
  end

  assign bus.match = match_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter (WIDTH=4, MOD=10, DIV=4).
// Define CNT_CMP_EN to also cover cmp/match.
module tb_mod_counter;
  import cnt_pkg::*;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int DV = 4;

  logic clk   = 1'b0;
  logic clear = 1'b1;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(W)) bus ();

  mod_counter #(
    .WIDTH(W),
    .MOD  (M),
    .DIV  (DV)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int tk    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d",
             tag, got, exp);
    end
  endtask

  function automatic bit mtick();
    return (n > 0) && (n % DV == 0);
  endfunction

  task automatic edge1();
    @(posedge clk);
    if (clear) n++;
    #1;
  endtask

  task automatic step1();
    bit was;
    do begin
      was = mtick();
      edge1();
    end while (!was);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sclr_n = 1'b1;
    bus.load_n = 1'b1;
    bus.d      = '0;
    bus.p      = 1'b0;
    bus.t      = 1'b0;
    bus.up     = 1'b1;
`ifdef CNT_CMP_EN
    bus.cmp    = 4'd3;
`endif
    #1 clear = 1'b0;
    #20;
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_tick", 32'(bus.tick), 0);
`ifdef CNT_CMP_EN
    chk("rst_match", 32'(bus.match), 0);
`endif
    @(negedge clk);
    clear = 1'b1;
    n = 0;

    // 1: async clear mid-count
    bus.load_n = 1'b0;
    bus.d = 4'd7;
    edge1();
    bus.load_n = 1'b1;
    chk("load7", 32'(bus.q), 7);
    while (!mtick()) edge1();
    chk("tick_hi", 32'(bus.tick), 1);
    clear = 1'b0;
    #1;
    chk("aclr_q", 32'(bus.q), 0);
    chk("aclr_tick", 32'(bus.tick), 0);
    bus.p  = 1'b1;
    bus.t  = 1'b1;
    bus.up = 1'b1;
    repeat (3) edge1();
    chk("aclr_hold", 32'(bus.q), 0);
    @(negedge clk);
    clear = 1'b1;
    n = 0;

    // 2: up count with wrap
    repeat (4) edge1();
    chk("lat_q", 32'(bus.q), 0);
    chk("lat_tick", 32'(bus.tick), 1);
    for (int i = 1; i <= 10; i++) begin
      step1();
      chk("up_q", 32'(bus.q), 32'(i % 10));
      chk("up_rco", 32'(bus.rco),
          32'((i % 10) == 9));
    end

    // 3: down count and T gating
    bus.up = 1'b0;
    #1;
    chk("dn_rco0", 32'(bus.rco), 1);
    bus.t = 1'b0;
    #1;
    chk("t0_rco", 32'(bus.rco), 0);
    repeat (8) edge1();
    chk("t0_hold", 32'(bus.q), 0);
    bus.t = 1'b1;
    step1();
    chk("dn_9", 32'(bus.q), 9);
    step1();
    chk("dn_8", 32'(bus.q), 8);

    // 4: out-of-range load
    while (mtick()) edge1();
    bus.load_n = 1'b0;
    bus.d = 4'hC;
    edge1();
    bus.load_n = 1'b1;
    chk("ld_C", 32'(bus.q), 12);
    bus.up = 1'b1;
    #1;
    chk("ld_rco", 32'(bus.rco), 0);
    step1();
    chk("C_up", 32'(bus.q), 0);
    while (mtick()) edge1();
    bus.load_n = 1'b0;
    edge1();
    bus.load_n = 1'b1;
    chk("ld_C2", 32'(bus.q), 12);
    bus.up = 1'b0;
    step1();
    chk("C_dn", 32'(bus.q), 11);

    // 5: sclr beats load; P gating
    bus.sclr_n = 1'b0;
    bus.load_n = 1'b0;
    bus.d = 4'd5;
    edge1();
    bus.sclr_n = 1'b1;
    bus.load_n = 1'b1;
    chk("sclr_win", 32'(bus.q), 0);
    chk("presc", 32'(bus.tick), 32'(mtick()));
    bus.p  = 1'b0;
    bus.up = 1'b1;
    tk = 0;
    repeat (32) begin
      edge1();
      if (bus.tick) tk++;
    end
    chk("p0_ticks", 32'(tk), 8);
    chk("p0_hold", 32'(bus.q), 0);
    bus.up = 1'b0;
    #1;
    chk("p0_rco", 32'(bus.rco), 1);

`ifdef CNT_CMP_EN
    // 6: compare
    bus.up = 1'b1;
    bus.p  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step1();
      chk("cmp_q", 32'(bus.q), 32'(i));
      chk("match", 32'(bus.match),
          32'(i == 3));
    end
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
